// File: rtl/text_render.sv
`default_nettype none
// =============================================================================
// Module   : text_render
// Purpose  : Text-mode pixel renderer. Turns VGA timing-generator coordinates
//            into one 3-bit RGB pixel per clock by fetching a character /
//            attribute word from video RAM and a glyph row from the font ROM.
//            The 640x480 visible area is an 80x60 grid of 8x8 glyphs. Syncs
//            and the active flag travel through a matching delay so colour
//            and sync leave the block aligned, five clocks after input.
//
// Ports    : clk, rst_n            pixel clock, async active-low reset
//            x, y, active          pixel position and visible-region flag
//            animate               end-of-frame strobe, advances blink counter
//            h_sync_in, v_sync_in  active-low syncs from the timing generator
//            vram_addr, vram_en    character cell read request (1-clk RAM)
//            vram_data             {blink, bg[2:0], rsvd, fg[2:0], char[7:0]}
//            font_addr, font_data  glyph row request / row bits (1-clk ROM),
//                                  font_data bit 7 is the leftmost pixel
//            rgb, h_sync, v_sync   aligned pixel colour and syncs
//
// Revision : 1.0  initial release
// =============================================================================
module text_render #(
    parameter int COLS       = 80,
    parameter int LATENCY    = 5,
    parameter int BLINK_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        active,
    input  logic        animate,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [12:0] vram_addr,
    output logic        vram_en,
    input  logic [15:0] vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [2:0]  rgb,
    output logic        h_sync,
    output logic        v_sync
);

    // Sidebands (sync, active) ride LATENCY-1 stages and then the output
    // register. The data path (address, RAM, font address, ROM, colour) is
    // fixed at five registers, so LATENCY has to stay at 5 to keep alignment.
    localparam int c_SB_DEPTH = LATENCY - 1;

    // -------------------------------------------------------------------------
    // Stage 1: character cell address
    // -------------------------------------------------------------------------
    logic [6:0]  w_row;
    logic [6:0]  w_col;
    logic [12:0] w_cell_addr;

    assign w_row = y[9:3];
    assign w_col = x[9:3];

    generate
        if (COLS == 80) begin : g_addr_shift_add
            // row*80 = row*64 + row*16, avoids a multiplier
            assign w_cell_addr = {w_row, 6'b0} + {2'b0, w_row, 4'b0} + {6'b0, w_col};
        end else begin : g_addr_mult
            localparam logic [12:0] c_COLS = 13'(COLS);
            assign w_cell_addr = {6'b0, w_row} * c_COLS + {6'b0, w_col};
        end
    endgenerate

    logic [12:0] r_vram_addr;
    logic        r_vram_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vram_addr <= 13'd0;
            r_vram_en   <= 1'b0;
        end else begin
            r_vram_en   <= active;
            // Outside the visible area the address is pinned to 0 so the RAM
            // is never addressed past cell 4799.
            r_vram_addr <= active ? w_cell_addr : 13'd0;
        end
    end

    assign vram_addr = r_vram_addr;
    assign vram_en   = r_vram_en;

    // -------------------------------------------------------------------------
    // Sideband delay lines, index 0 is stage 1
    // -------------------------------------------------------------------------
    logic [c_SB_DEPTH-1:0] r_hs_pipe;
    logic [c_SB_DEPTH-1:0] r_vs_pipe;
    logic [c_SB_DEPTH-1:0] r_act_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_pipe  <= '1;
            r_vs_pipe  <= '1;
            r_act_pipe <= '0;
        end else begin
            r_hs_pipe  <= {r_hs_pipe[c_SB_DEPTH-2:0], h_sync_in};
            r_vs_pipe  <= {r_vs_pipe[c_SB_DEPTH-2:0], v_sync_in};
            r_act_pipe <= {r_act_pipe[c_SB_DEPTH-2:0], active};
        end
    end

    // -------------------------------------------------------------------------
    // Glyph sub-position: y3 is needed when the font address is formed
    // (stage 3), x3 when the pixel is picked out of the glyph row (stage 5).
    // -------------------------------------------------------------------------
    logic [2:0] r_y3_1;
    logic [2:0] r_y3_2;
    logic [2:0] r_x3_1;
    logic [2:0] r_x3_2;
    logic [2:0] r_x3_3;
    logic [2:0] r_x3_4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y3_1 <= 3'd0;
            r_y3_2 <= 3'd0;
            r_x3_1 <= 3'd0;
            r_x3_2 <= 3'd0;
            r_x3_3 <= 3'd0;
            r_x3_4 <= 3'd0;
        end else begin
            r_y3_1 <= y[2:0];
            r_y3_2 <= r_y3_1;
            r_x3_1 <= x[2:0];
            r_x3_2 <= r_x3_1;
            r_x3_3 <= r_x3_2;
            r_x3_4 <= r_x3_3;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: font address and attribute capture from video RAM data.
    // Attribute is kept packed as {blink, bg[2:0], fg[2:0]}.
    // -------------------------------------------------------------------------
    logic [10:0] r_font_addr;
    logic [6:0]  r_attr3;
    logic [6:0]  r_attr4;
    logic        w_unused_rsvd;

    assign w_unused_rsvd = vram_data[11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_font_addr <= 11'd0;
            r_attr3     <= 7'd0;
            r_attr4     <= 7'd0;
        end else begin
            r_font_addr <= {vram_data[7:0], r_y3_2};
            r_attr3     <= {vram_data[15], vram_data[14:12], vram_data[10:8]};
            r_attr4     <= r_attr3;
        end
    end

    assign font_addr = r_font_addr;

    // -------------------------------------------------------------------------
    // Blink counter: advances once per frame, MSB is the hide phase.
    // -------------------------------------------------------------------------
    logic [BLINK_BITS-1:0] r_blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
        end else if (animate) begin
            r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 5: colour select and aligned sync output
    // -------------------------------------------------------------------------
    logic       w_pixel;
    logic       w_blink;
    logic       w_phase;
    logic [2:0] w_fg;
    logic [2:0] w_bg;
    logic [2:0] w_fg_eff;
    logic [2:0] w_rgb_next;

    // 7 - x3 equals ~x3 for a 3-bit value: bit 7 is the leftmost pixel
    assign w_pixel  = font_data[~r_x3_4];
    assign w_blink  = r_attr4[6];
    assign w_bg     = r_attr4[5:3];
    assign w_fg     = r_attr4[2:0];
    assign w_phase  = r_blink_cnt[BLINK_BITS-1];
    // Hidden phase paints the glyph in the background colour
    assign w_fg_eff = (w_blink && w_phase) ? w_bg : w_fg;

    always_comb begin
        w_rgb_next = 3'b000;
        if (r_act_pipe[c_SB_DEPTH-1]) begin
            w_rgb_next = w_pixel ? w_fg_eff : w_bg;
        end
    end

    logic [2:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= 3'b000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb_next;
            r_hsync <= r_hs_pipe[c_SB_DEPTH-1];
            r_vsync <= r_vs_pipe[c_SB_DEPTH-1];
        end
    end

    assign rgb    = r_rgb;
    assign h_sync = r_hsync;
    assign v_sync = r_vsync;

endmodule
`default_nettype wire

// File: doc/text_render.md
# text_render

Text-mode pixel renderer directly downstream of the VGA timing generator. Consumes the generator's pixel coordinates, active flag, frame strobe and sync signals. Fetches character/attribute words from video RAM and glyph rows from the font ROM, and emits one 3-bit RGB pixel per clock. The 640x480 display is treated as an 80x60 grid of 8x8 glyphs. Syncs and blanking are delayed through a matching pipeline so the monitor sees aligned colour and sync.

## Interface
- COLS, 80, characters per row; row stride of video RAM
- LATENCY, 5, fixed input-to-output delay in clocks; not user-tunable, documents the pipeline
- BLINK_BITS, 5, width of frame counter; blink phase = MSB

- clk  in  1  pixel clock, same clock as the timing generator
- rst_n  in  1  asynchronous active-low reset
- x  in  10  pixel column from timing generator, 0..799
- y  in  10  pixel row from timing generator, 0..524
- active  in  1  high inside 640x480 visible region
- animate  in  1  one-clock strobe at x=799,y=479 (end of visible frame)
- h_sync_in  in  1  horizontal sync, active low
- v_sync_in  in  1  vertical sync, active low
- vram_addr  out  13  character cell address, 0..4799
- vram_en  out  1  read enable to video RAM
- vram_data  in  16  [7:0] char code, [10:8] fg RGB, [14:12] bg RGB, [15] blink, [11] reserved
- font_addr  out  11  {char code, glyph row y[2:0]}
- font_data  in  8  glyph row; bit 7 = leftmost pixel
- rgb  out  3  pixel colour {r,g,b}
- h_sync  out  1  h_sync_in delayed LATENCY clocks
- v_sync  out  1  v_sync_in delayed LATENCY clocks

## Operation
- Video RAM and font ROM are synchronous single-port reads: address sampled on a clock edge, data valid after that edge (1-clock latency).
- Pipeline. Edges E1..E5 follow the clock in which x/y are presented:
  - E1: register vram_addr = (y>>3)*80 + (x>>3) when active, else 0. vram_en = active. Shift-add form: row*64 + row*16. Also capture x[2:0], y[2:0], active, h_sync_in, v_sync_in into stage 1.
  - E2: RAM samples vram_addr. Sidebands advance to stage 2.
  - E3: register font_addr = {vram_data[7:0], y3}. Register attribute bits [15:8]. Sidebands advance to stage 3.
  - E4: ROM samples font_addr. Sidebands and attribute advance to stage 4.
  - E5: pixel = font_data[7 - x3]. Register rgb and output sync.
- Colour select at E5:
  - rgb = 0 if the stage-4 active bit is 0.
  - Otherwise rgb = fg if pixel=1, else bg.
  - If blink=1 and blink phase=1, fg is replaced by bg, so the glyph is hidden.
- Blink counter:
  - BLINK_BITS-wide, increments by 1 on each clock with animate=1 and wraps 31->0.
  - The phase is the counter MSB, so the glyph is visible for 16 frames and hidden for 16.
  - The phase is sampled at E5. A change mid-frame is impossible because animate occurs only during blanking.
- Address range:
  - Active region: max address (59*80+79) = 4799.
  - Outside the active region the address is forced to 0, so RAM is never read out of range.
- No handshake, no stall. The pipeline advances every clock unconditionally.

## Timing
- Reset values:
  - rgb = 0, h_sync = 1, v_sync = 1.
  - vram_addr = 0, vram_en = 0, font_addr = 0.
  - Blink counter = 0.
  - All pipeline sync stages = 1, all active stages = 0.
- Reset asserted mid-line: outputs go to reset values immediately (asynchronous).
- After reset release, the first LATENCY clocks emit blank pixels with syncs inactive; valid output follows.
- Latency, identical for rgb, h_sync and v_sync:
  - Inputs presented in clock t appear on the outputs after edge t+5.
  - x=0 of a visible line reaches rgb exactly 5 clocks after x=0 appears on the input.
- animate and an active pixel never coincide.
- animate coinciding with reset release is ignored; the counter stays 0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> rgb=0, h_sync=1, v_sync=1, vram_en=0 on every clock. Release -> 5 blank clocks.
- Address mapping:
  - x=0,y=0 -> vram_addr=0.
  - x=8,y=8 -> 81.
  - x=639,y=479 -> 4799.
  - x=700,y=100 (inactive) -> 0 with vram_en=0.
- Single glyph:
  - Cell 0 = 0x0741 ('A', fg 7, bg 0); ROM row 0 of 0x41 = 0x18.
  - Line y=0, x=0..7 -> rgb sequence 0,0,0,7,7,0,0,0 starting 5 clocks after x=0.
  - font_addr = 0x208 at E3.
- Sync alignment: drive h_sync_in low for x=655..750 -> h_sync low for exactly the same 96 clocks, shifted by 5. Check the same rule on v_sync.
- Blanking: a cell with bg=5 at the last column -> rgb=5 at visible pixels, rgb=0 from x=640 onward (shifted by 5).
- Blink:
  - Cell 0x8741 ('A' with blink set). Run 16 frames of animate pulses -> glyph hidden (rgb=bg) during frames 16..31, visible for frames 0..15 and again after 32 pulses.
  - The same cell with bit 15 = 0 is never hidden.
